// File: rtl/inst_seq_pkg.sv
// Shared constants for the instruction memory sequencer: opcodes, instruction
// field positions and the sequencer FSM state type.
package inst_seq_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;

    // Instruction layout: {opcode, addr, length, port, pad}
    localparam int unsigned OPC_MSB  = 26;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned ADDR_MSB = 23;
    localparam int unsigned ADDR_LSB = 12;
    localparam int unsigned LEN_MSB  = 11;
    localparam int unsigned LEN_LSB  = 6;
    localparam int unsigned PORT_MSB = 5;
    localparam int unsigned PORT_LSB = 4;
    localparam int unsigned PAD_MSB  = 3;
    localparam int unsigned PAD_LSB  = 0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/inst_mem_sequencer_if.sv
// Instruction input and memory-port output bundle of the sequencer.
// master: instruction source / observer side; slave: the sequencer itself.
interface inst_mem_sequencer_if #(
    parameter int unsigned INST_WIDTH = 27,
    parameter int unsigned ADDR_WIDTH = 12
) ();
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  inst_ready;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [1:0]            mem_port;
    logic                  done;
    logic                  err;
    logic                  ovf;
    logic                  busy;

    modport master (
        output inst, inst_valid,
        input  inst_ready, mem_en, mem_we, mem_addr, mem_port, done, err, ovf, busy
    );

    modport slave (
        input  inst, inst_valid,
        output inst_ready, mem_en, mem_we, mem_addr, mem_port, done, err, ovf, busy
    );
endinterface

// File: rtl/inst_fifo.sv
// Synchronous FIFO with a registered occupancy count; full/empty come from the
// count only. DEPTH must be a power of two so the pointers wrap naturally.
module inst_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/inst_mem_sequencer.sv
// Instruction memory sequencer: queues transfer instructions and expands each
// into a burst of single-word accesses on one of four memory ports.
// Optional feature macro: INST_SEQ_STRIDE_EN (pad field sets address stride 1..16).
module inst_mem_sequencer
    import inst_seq_pkg::*;
#(
    parameter int unsigned INST_WIDTH = 27,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    inst_mem_sequencer_if.slave bus
);
    logic [INST_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_skip;
    logic [ADDR_WIDTH-1:0] w_stride;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [1:0]            r_port;
    logic                  r_we;
    logic                  r_ovf;

    // Ready depends on the registered count only, so a same-cycle pop never frees a slot
    assign w_push = bus.inst_valid && !w_full;
    assign w_pop  = (r_state == StIdle) && !w_empty;

    inst_fifo #(
        .WIDTH (INST_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (bus.inst),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Illegal or zero-length instructions retire without any access
    assign w_head_skip = !op_legal(w_head[OPC_MSB:OPC_LSB]) ||
                         (w_head[LEN_MSB:LEN_LSB] == '0);

`ifdef INST_SEQ_STRIDE_EN
    logic [3:0] r_pad;

    // Stride field captured at pop alongside the other instruction fields
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pad <= '0;
        end else if (w_pop) begin
            r_pad <= w_head[PAD_MSB:PAD_LSB];
        end
    end

    assign w_stride = ADDR_WIDTH'(r_pad) + ADDR_WIDTH'(1);
`else
    logic w_unused_pad;
    assign w_unused_pad = ^w_head[PAD_MSB:PAD_LSB];
    assign w_stride     = ADDR_WIDTH'(1);
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_nxt = w_head_skip ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (r_rem == LEN_WIDTH'(1)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Instruction latch at pop, then address/remaining stepping while issuing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op   <= OP_LOAD;
            r_addr <= '0;
            r_rem  <= '0;
            r_port <= '0;
            r_we   <= 1'b0;
        end else if (w_pop) begin
            r_op   <= w_head[OPC_MSB:OPC_LSB];
            r_addr <= w_head[ADDR_MSB:ADDR_LSB];
            r_rem  <= w_head[LEN_MSB:LEN_LSB];
            r_port <= w_head[PORT_MSB:PORT_LSB];
            r_we   <= (w_head[OPC_MSB:OPC_LSB] == OP_STORE);
        end else if (r_state == StIssue) begin
            r_addr <= r_addr + w_stride;
            r_rem  <= r_rem - LEN_WIDTH'(1);
        end
    end

    // Overflow pulse one cycle after a dropped instruction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= bus.inst_valid && w_full;
        end
    end

    assign bus.inst_ready = !w_full;
    assign bus.mem_en     = (r_state == StIssue);
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_port   = r_port;
    assign bus.done       = (r_state == StDone);
    assign bus.err        = (r_state == StDone) && !op_legal(r_op);
    assign bus.ovf        = r_ovf;
    assign bus.busy       = (r_state != StIdle) || !w_empty;

endmodule
